// File: rtl/csr_trap_seq.sv
// ----------------------------------------------------------------------------
// csr_trap_seq
//
// Purpose:
//   Owns the single write port of the CSR file. Ordinary CSR-instruction
//   writes from write-back pass straight through with zero latency. A trap
//   seen in WB starts a multi-cycle save sequence (mepc, mcause, optionally
//   mtval). During that sequence the pipeline is frozen. The sequence ends
//   with a one-cycle fetch redirect to the trap vector. An mret redirects
//   fetch to mepc in the same cycle it is seen.
//
// Configuration:
//   WRITE_MTVAL       : 1 -> the mtval save cycle is included,
//                       0 -> WR_CAUSE goes directly to REDIRECT.
//   TRAP_VECTORED_EN  : when defined, an interrupt cause taken with
//                       mtvec.MODE == 1 is vectored to base + 4*cause[4:0].
//                       When undefined, the direct base is always used.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wb_valid_i          WB holds a valid instruction
//   wb_csr_we_i         WB instruction writes a CSR
//   wb_csr_waddr_i      CSR write address from WB
//   wb_csr_wdata_i      CSR write data from WB
//   wb_trap_valid_i     WB instruction traps
//   wb_trap_pc_i        PC of the trapping instruction
//   wb_trap_mcause_i    trap cause
//   wb_trap_mtval_i     trap value
//   wb_mret_i           WB instruction is mret
//   mtvec_i, mepc_i     current mtvec / mepc from the CSR file
//   csr_we_o            CSR file write enable
//   csr_waddr_o         CSR file write address
//   csr_wdata_o         CSR file write data
//   stall_o             freeze all pipeline stages
//   flush_o             kill IF/ID/EX/MEM contents
//   redirect_valid_o    fetch redirect strobe
//   redirect_pc_o       fetch redirect target (0 when no redirect)
//   busy_o              trap sequence in progress
// ----------------------------------------------------------------------------
module csr_trap_seq #(
  parameter bit WRITE_MTVAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic        wb_csr_we_i,
  input  logic [11:0] wb_csr_waddr_i,
  input  logic [31:0] wb_csr_wdata_i,
  input  logic        wb_trap_valid_i,
  input  logic [31:0] wb_trap_pc_i,
  input  logic [31:0] wb_trap_mcause_i,
  input  logic [31:0] wb_trap_mtval_i,
  input  logic        wb_mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_EPC   = 3'd1,
    WR_CAUSE = 3'd2,
    WR_TVAL  = 3'd3,
    REDIRECT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;

  // WB qualifiers only count when the WB slot is valid; a trap always
  // wins over mret and over the instruction's own CSR write.
  logic trap_take;
  logic mret_take;
  logic csr_take;

  assign trap_take = wb_valid_i & wb_trap_valid_i;
  assign mret_take = wb_valid_i & wb_mret_i & ~wb_trap_valid_i;
  assign csr_take  = wb_valid_i & wb_csr_we_i & ~wb_trap_valid_i;

  // Trap vector target, computed from mtvec as it stands in REDIRECT so a
  // mtvec write that retired just before the trap is honoured.
  logic [31:0] vec_base;
  logic [31:0] vec_target;

  assign vec_base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    vec_target = vec_base;
    if ((mtvec_i[1:0] == 2'b01) && cause_q[31]) begin
      // Natural 32-bit wrap on overflow.
      vec_target = vec_base + {25'd0, cause_q[4:0], 2'b00};
    end
  end
`else
  // mtvec MODE bits are irrelevant for direct-only trapping.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
  assign vec_target        = vec_base;
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    case (state_q)
      IDLE: begin
        if (trap_take) begin
          pc_d    = wb_trap_pc_i;
          cause_d = wb_trap_mcause_i;
          tval_d  = wb_trap_mtval_i;
          state_d = WR_EPC;
        end
      end
      WR_EPC:   state_d = WR_CAUSE;
      WR_CAUSE: state_d = WRITE_MTVAL ? WR_TVAL : REDIRECT;
      WR_TVAL:  state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  // Output decode. In IDLE the outputs follow WB combinationally so a
  // plain CSR write, a trap flush or an mret redirect costs no cycle; in
  // the save states they depend only on registered state and captures.
  always_comb begin
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      IDLE: begin
        if (trap_take) begin
          // Trapping instruction does not retire: its CSR write is dropped.
          flush_o = 1'b1;
        end else begin
          if (mret_take) begin
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = mepc_i;
          end
          if (csr_take) begin
            csr_we_o    = 1'b1;
            csr_waddr_o = wb_csr_waddr_i;
            csr_wdata_o = wb_csr_wdata_i;
          end
        end
      end
      WR_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_MEPC;
        csr_wdata_o = {pc_q[31:2], 2'b00};
      end
      WR_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      WR_TVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_MTVAL;
        csr_wdata_o = tval_q;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = vec_target;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o;

endmodule

// File: tb/tb_csr_trap_seq.sv
// ----------------------------------------------------------------------------
// tb_csr_trap_seq
//
// Directed testbench for csr_trap_seq (default WRITE_MTVAL = 1). Inputs are
// driven just after the falling clock edge and outputs are sampled 1 ns
// later, well away from the rising edge. Expected values are hand-computed.
// Build with +define+TRAP_VECTORED_EN to check the vectored redirect target.
// ----------------------------------------------------------------------------
module tb_csr_trap_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic        wb_csr_we_i;
  logic [11:0] wb_csr_waddr_i;
  logic [31:0] wb_csr_wdata_i;
  logic        wb_trap_valid_i;
  logic [31:0] wb_trap_pc_i;
  logic [31:0] wb_trap_mcause_i;
  logic [31:0] wb_trap_mtval_i;
  logic        wb_mret_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  csr_trap_seq dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wb_valid_i       (wb_valid_i),
    .wb_csr_we_i      (wb_csr_we_i),
    .wb_csr_waddr_i   (wb_csr_waddr_i),
    .wb_csr_wdata_i   (wb_csr_wdata_i),
    .wb_trap_valid_i  (wb_trap_valid_i),
    .wb_trap_pc_i     (wb_trap_pc_i),
    .wb_trap_mcause_i (wb_trap_mcause_i),
    .wb_trap_mtval_i  (wb_trap_mtval_i),
    .wb_mret_i        (wb_mret_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .csr_we_o         (csr_we_o),
    .csr_waddr_o      (csr_waddr_o),
    .csr_wdata_o      (csr_wdata_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Check the whole output bundle at once.
  task automatic chk_out(input string tag, input logic we, input logic [11:0] wa,
                         input logic [31:0] wd, input logic st, input logic fl,
                         input logic rv, input logic [31:0] rp);
    chk_val({tag, ".we"},    32'(csr_we_o),         32'(we));
    chk_val({tag, ".waddr"}, 32'(csr_waddr_o),      32'(wa));
    chk_val({tag, ".wdata"}, csr_wdata_o,           wd);
    chk_val({tag, ".stall"}, 32'(stall_o),          32'(st));
    chk_val({tag, ".busy"},  32'(busy_o),           32'(st));
    chk_val({tag, ".flush"}, 32'(flush_o),          32'(fl));
    chk_val({tag, ".rvld"},  32'(redirect_valid_o), 32'(rv));
    chk_val({tag, ".rpc"},   redirect_pc_o,         rp);
  endtask

  task automatic wb_idle();
    wb_valid_i       = 1'b0;
    wb_csr_we_i      = 1'b0;
    wb_csr_waddr_i   = '0;
    wb_csr_wdata_i   = '0;
    wb_trap_valid_i  = 1'b0;
    wb_trap_pc_i     = '0;
    wb_trap_mcause_i = '0;
    wb_trap_mtval_i  = '0;
    wb_mret_i        = 1'b0;
  endtask

  // Advance one cycle: drive after the falling edge, sample 1 ns later.
  task automatic next_cyc();
    @(negedge clk_i);
    #1;
  endtask

  // Full trap sequence with WRITE_MTVAL = 1. When junk is set, WB also
  // requests a CSR write at T and keeps presenting valid junk during the
  // sequence, which must all be ignored.
  task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] mtvec,
                          input logic [31:0] exp_rpc, input logic junk);
    @(negedge clk_i);
    mtvec_i          = mtvec;
    wb_valid_i       = 1'b1;
    wb_trap_valid_i  = 1'b1;
    wb_trap_pc_i     = pc;
    wb_trap_mcause_i = cause;
    wb_trap_mtval_i  = tval;
    wb_csr_we_i      = junk;
    wb_csr_waddr_i   = 12'h300;
    wb_csr_wdata_i   = 32'h5555_AAAA;
    #1;
    chk_out({tag, ".T"}, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    wb_idle();
    if (junk) begin
      wb_valid_i       = 1'b1;
      wb_csr_we_i      = 1'b1;
      wb_csr_waddr_i   = 12'h305;
      wb_csr_wdata_i   = 32'hFFFF_FFFF;
      wb_trap_valid_i  = 1'b1;
      wb_trap_pc_i     = 32'hAAAA_AAAA;
      wb_trap_mcause_i = 32'h9;
      wb_mret_i        = 1'b1;
    end
    #1;
    chk_out({tag, ".T1"}, 1'b1, 12'h341, {pc[31:2], 2'b00}, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cyc();
    chk_out({tag, ".T2"}, 1'b1, 12'h342, cause, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cyc();
    chk_out({tag, ".T3"}, 1'b1, 12'h343, tval, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cyc();
    chk_out({tag, ".T4"}, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b1, exp_rpc);
    @(negedge clk_i);
    wb_idle();
    #1;
    chk_out({tag, ".T5"}, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_vec;
    rst_i   = 1'b1;
    mtvec_i = 32'h0;
    mepc_i  = 32'h0;
    wb_idle();

    // Reset state.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk_out("reset", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Plain CSR write passes through in the same cycle.
    wb_valid_i     = 1'b1;
    wb_csr_we_i    = 1'b1;
    wb_csr_waddr_i = 12'h340;
    wb_csr_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk_out("csr_pass", 1'b1, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);

    // Same write without wb_valid has no effect; trap without valid too.
    @(negedge clk_i);
    wb_valid_i      = 1'b0;
    wb_trap_valid_i = 1'b1;
    wb_mret_i       = 1'b1;
    mepc_i          = 32'h0000_3000;
    #1;
    chk_out("novalid", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    wb_idle();
    #1;
    chk_out("novalid.next", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Trap sequence, then trap taking priority over its own CSR write.
    run_trap("trap", 32'h0000_1006, 32'd2, 32'h0000_1234, 32'h8000_0103, 32'h8000_0100, 1'b0);
    run_trap("trap_we", 32'h0000_1006, 32'd2, 32'h0000_1234, 32'h8000_0103, 32'h8000_0100, 1'b1);

    // mret: same-cycle redirect to mepc, stays idle.
    @(negedge clk_i);
    wb_valid_i = 1'b1;
    wb_mret_i  = 1'b1;
    mepc_i     = 32'h0000_2000;
    #1;
    chk_out("mret", 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
    @(negedge clk_i);
    wb_idle();
    #1;
    chk_out("mret.next", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset asserted during WR_CAUSE abandons the sequence.
    @(negedge clk_i);
    wb_valid_i       = 1'b1;
    wb_trap_valid_i  = 1'b1;
    wb_trap_pc_i     = 32'h0000_4008;
    wb_trap_mcause_i = 32'd5;
    wb_trap_mtval_i  = 32'h77;
    @(negedge clk_i);
    wb_idle();
    next_cyc();
    chk_out("rst_mid.cause", 1'b1, 12'h342, 32'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    next_cyc();
    chk_out("rst_mid.after", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk_out("rst_mid.rel", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cyc();
    chk_out("rst_mid.idle", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Interrupt with vectored mtvec.
`ifdef TRAP_VECTORED_EN
    exp_vec = 32'h8000_001C;
`else
    exp_vec = 32'h8000_0000;
`endif
    run_trap("vec", 32'h0000_0100, 32'h8000_0007, 32'h0, 32'h8000_0001, exp_vec, 1'b0);
    // Exception (cause[31] = 0) with vectored mode still uses the base.
    run_trap("vec_exc", 32'h0000_0200, 32'h0000_0007, 32'h9, 32'h8000_0001, 32'h8000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
